// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter running on the bit clock (one CLK cycle per bit).
// Frame on TX_OUT: start (0), DATA_WIDTH data bits LSB-first, optional parity, stop (1).
// Build option: define UART_TX_TWO_STOP_EN to hold the stop bit for two cycles.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
`ifdef UART_TX_TWO_STOP_EN
  logic                    stop_cnt_q, stop_cnt_d;
`endif

  // Even parity makes the total count of ones even; odd parity is its inverse.
  function automatic logic parity_calc(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // State and datapath registers; reset aborts any frame and idles the line high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  // Next state plus the line value for the coming bit period, so TX_OUT is registered.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          shreg_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = parity_calc(P_DATA, PAR_TYP);
          cnt_d     = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_START: begin
        state_d = S_DATA;
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt_d = 1'b0;
`endif
          end
        end else begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
        tx_d    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_d = 1'b0;
`endif
      end
      S_STOP: begin
        tx_d = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        if (!stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
`endif
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
